// File: rtl/ysyx_23060124_wbu.sv
// Write-back stage: latches one retired instruction, issues a single
// register-file write, then holds the commit token until fetch takes it.
module ysyx_23060124_wbu #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_dnpc,
  input  logic [XLEN-1:0]  in_alu_res,
  input  logic [XLEN-1:0]  in_lsu_rdata,
  input  logic [XLEN-1:0]  in_csr_rdata,
  input  logic [1:0]       in_wb_sel,
  input  logic [2:0]       in_ld_fmt,
  input  logic [RF_AW-1:0] in_rd,
  input  logic             in_rd_wen,
  output logic             rf_wen,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             cm_valid,
  input  logic             cm_ready,
  output logic [XLEN-1:0]  cm_pc,
  output logic [XLEN-1:0]  cm_dnpc
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;
  localparam logic [1:0] SEL_CSR  = 2'd3;

  localparam logic [2:0] FMT_LB  = 3'd0;
  localparam logic [2:0] FMT_LH  = 3'd1;
  localparam logic [2:0] FMT_LBU = 3'd4;
  localparam logic [2:0] FMT_LHU = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e          state, state_d;
  logic            accept;
  logic            in_ready_d;
  logic            rf_wen_d;
  logic            cm_valid_d;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] result;

  // Load extension and result select on the instruction captured at the handshake edge
  always_comb begin
    ld_data = in_lsu_rdata;
    case (in_ld_fmt)
      FMT_LB:  ld_data = {{(XLEN-BYTE_W){in_lsu_rdata[BYTE_W-1]}}, in_lsu_rdata[BYTE_W-1:0]};
      FMT_LH:  ld_data = {{(XLEN-HALF_W){in_lsu_rdata[HALF_W-1]}}, in_lsu_rdata[HALF_W-1:0]};
      FMT_LBU: ld_data = {{(XLEN-BYTE_W){1'b0}}, in_lsu_rdata[BYTE_W-1:0]};
      FMT_LHU: ld_data = {{(XLEN-HALF_W){1'b0}}, in_lsu_rdata[HALF_W-1:0]};
      default: ld_data = in_lsu_rdata;
    endcase
    result = in_alu_res;
    case (in_wb_sel)
      SEL_ALU:  result = in_alu_res;
      SEL_LOAD: result = ld_data;
      SEL_PC4:  result = in_pc + XLEN'(4);
      SEL_CSR:  result = in_csr_rdata;
      default:  result = in_alu_res;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state and next values of the registered control outputs
  always_comb begin
    state_d    = state;
    accept     = 1'b0;
    in_ready_d = 1'b0;
    rf_wen_d   = 1'b0;
    cm_valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          state_d  = WB;
          rf_wen_d = in_rd_wen && (in_rd != '0);
        end else begin
          in_ready_d = 1'b1;
        end
      end
      WB: begin
        state_d    = COMMIT;
        cm_valid_d = 1'b1;
      end
      COMMIT: begin
        if (cm_ready) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end else begin
          cm_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  // Registered control outputs
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
      rf_wen   <= 1'b0;
      cm_valid <= 1'b0;
    end else begin
      in_ready <= in_ready_d;
      rf_wen   <= rf_wen_d;
      cm_valid <= cm_valid_d;
    end
  end

  // Payload captured once per accepted instruction and held through commit
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rf_waddr <= '0;
      rf_wdata <= '0;
      cm_pc    <= '0;
      cm_dnpc  <= '0;
    end else if (accept) begin
      rf_waddr <= in_rd;
      rf_wdata <= result;
      cm_pc    <= in_pc;
      cm_dnpc  <= in_dnpc;
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Directed bench for the write-back stage.
module tb_ysyx_23060124_wbu;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_dnpc, in_alu_res, in_lsu_rdata, in_csr_rdata;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_ld_fmt;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        cm_valid;
  logic        cm_ready;
  logic [31:0] cm_pc, cm_dnpc;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int wen_cnt = 0;
  logic [31:0] wq[$];
  logic [31:0] cq[$];

  ysyx_23060124_wbu dut (
    .clock(clock), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_dnpc(in_dnpc), .in_alu_res(in_alu_res),
    .in_lsu_rdata(in_lsu_rdata), .in_csr_rdata(in_csr_rdata),
    .in_wb_sel(in_wb_sel), .in_ld_fmt(in_ld_fmt), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_pc(cm_pc), .cm_dnpc(cm_dnpc)
  );

  always #5 clock = ~clock;

  // Count write strobes and log writes/commits mid-cycle
  always @(negedge clock) begin
    if (rf_wen) begin
      wen_cnt = wen_cnt + 1;
      wq.push_back(rf_wdata);
    end
    if (cm_valid && cm_ready) cq.push_back(cm_pc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] dnpc, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] csr, input logic [1:0] sel,
                       input logic [2:0] fmt, input logic [4:0] rd, input logic wen);
    in_pc = pc; in_dnpc = dnpc; in_alu_res = alu; in_lsu_rdata = rdata; in_csr_rdata = csr;
    in_wb_sel = sel; in_ld_fmt = fmt; in_rd = rd; in_rd_wen = wen;
  endtask

  // One full instruction with cm_ready=1; live inputs are scrambled after the handshake
  task automatic run_op(input string name, input logic [31:0] pc, input logic [31:0] dnpc,
                        input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] csr,
                        input logic [1:0] sel, input logic [2:0] fmt, input logic [4:0] rd,
                        input logic wen, input logic exp_wen, input logic [31:0] exp_wdata);
    chk({name, "_ready_idle"}, 32'(in_ready), 32'd1);
    drive(pc, dnpc, alu, rdata, csr, sel, fmt, rd, wen);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drive(~pc, ~dnpc, ~alu, ~rdata, ~csr, ~sel, ~fmt, ~rd, ~wen);
    chk({name, "_wen"}, 32'(rf_wen), 32'(exp_wen));
    chk({name, "_ready_wb"}, 32'(in_ready), 32'd0);
    if (exp_wen) begin
      chk({name, "_waddr"}, 32'(rf_waddr), 32'(rd));
      chk({name, "_wdata"}, rf_wdata, exp_wdata);
    end
    tick();
    chk({name, "_cm_valid"}, 32'(cm_valid), 32'd1);
    chk({name, "_wen_off"}, 32'(rf_wen), 32'd0);
    chk({name, "_cm_pc"}, cm_pc, pc);
    chk({name, "_cm_dnpc"}, cm_dnpc, dnpc);
    tick();
    chk({name, "_cm_done"}, 32'(cm_valid), 32'd0);
  endtask

  initial begin
    int w0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    cm_ready = 1'b1;
    drive('0, '0, '0, '0, '0, 2'd0, 3'd0, 5'd0, 1'b0);
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_cm_valid", 32'(cm_valid), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_cm_pc", cm_pc, 32'd0);
    chk("rst_cm_dnpc", cm_dnpc, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_hold_ready", 32'(in_ready), 32'd1);
    chk("idle_hold_wen", 32'(rf_wen), 32'd0);

    // Result mux and load extension
    run_op("alu", 32'h8000_0000, 32'h8000_0004, 32'h1234, 32'h0, 32'h0, 2'd0, 3'd2, 5'd5, 1'b1, 1'b1, 32'h0000_1234);
    run_op("lb",  32'h8000_0010, 32'h8000_0014, 32'h0, 32'hDEAD_BE80, 32'h0, 2'd1, 3'd0, 5'd6, 1'b1, 1'b1, 32'hFFFF_FF80);
    run_op("lbu", 32'h8000_0020, 32'h8000_0024, 32'h0, 32'hDEAD_BE80, 32'h0, 2'd1, 3'd4, 5'd6, 1'b1, 1'b1, 32'h0000_0080);
    run_op("lh",  32'h8000_0030, 32'h8000_0034, 32'h0, 32'hDEAD_BE80, 32'h0, 2'd1, 3'd1, 5'd6, 1'b1, 1'b1, 32'hFFFF_BE80);
    run_op("lhu", 32'h8000_0040, 32'h8000_0044, 32'h0, 32'hDEAD_BE80, 32'h0, 2'd1, 3'd5, 5'd6, 1'b1, 1'b1, 32'h0000_BE80);
    run_op("lw",  32'h8000_0050, 32'h8000_0054, 32'h0, 32'hDEAD_BE80, 32'h0, 2'd1, 3'd2, 5'd6, 1'b1, 1'b1, 32'hDEAD_BE80);
    run_op("fmt3", 32'h8000_0060, 32'h8000_0064, 32'h0, 32'h1357_9BDF, 32'h0, 2'd1, 3'd3, 5'd6, 1'b1, 1'b1, 32'h1357_9BDF);
    run_op("jal", 32'hFFFF_FFFC, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 2'd2, 3'd0, 5'd1, 1'b1, 1'b1, 32'h0000_0000);
    run_op("pc4", 32'h8000_0100, 32'h8000_0200, 32'h0, 32'h0, 32'h0, 2'd2, 3'd0, 5'd1, 1'b1, 1'b1, 32'h8000_0104);
    run_op("csr", 32'h8000_0070, 32'h8000_0074, 32'h0, 32'h0, 32'hCAFE_F00D, 2'd3, 3'd0, 5'd10, 1'b1, 1'b1, 32'hCAFE_F00D);
    w0 = wen_cnt;
    run_op("store", 32'h8000_0080, 32'h8000_0084, 32'h55, 32'h0, 32'h0, 2'd0, 3'd2, 5'd3, 1'b0, 1'b0, 32'h0);
    run_op("rd0", 32'h8000_0090, 32'h8000_0094, 32'h66, 32'h0, 32'h0, 2'd0, 3'd2, 5'd0, 1'b1, 1'b0, 32'h0);
    chk("no_write_cnt", 32'(wen_cnt - w0), 32'd0);

    // Backpressure with a competing offer during the stall
    cm_ready = 1'b0;
    w0 = wen_cnt;
    drive(32'h100, 32'h104, 32'hAA, 32'h0, 32'h0, 2'd0, 3'd2, 5'd7, 1'b1);
    in_valid = 1'b1;
    tick();
    drive(32'h200, 32'h204, 32'hBB, 32'h0, 32'h0, 2'd0, 3'd2, 5'd8, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_cm_valid", 32'(cm_valid), 32'd1);
      chk("bp_cm_pc", cm_pc, 32'h100);
      chk("bp_cm_dnpc", cm_dnpc, 32'h104);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_wen", 32'(rf_wen), 32'd0);
      tick();
    end
    chk("bp_one_write", 32'(wen_cnt - w0), 32'd1);
    cm_ready = 1'b1;
    tick();
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_cm", 32'(cm_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_next_wen", 32'(rf_wen), 32'd1);
    chk("bp_next_waddr", 32'(rf_waddr), 32'd8);
    chk("bp_next_wdata", rf_wdata, 32'hBB);
    tick();
    chk("bp_next_cm_pc", cm_pc, 32'h200);
    tick();

    // Reset while holding a commit
    cm_ready = 1'b0;
    drive(32'h300, 32'h304, 32'hCC, 32'h0, 32'h0, 2'd0, 3'd2, 5'd9, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_cm_valid", 32'(cm_valid), 32'd1);
    rst_n = 1'b0;
    w0 = wen_cnt;
    tick();
    chk("mid_rst_cm_valid", 32'(cm_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    cm_ready = 1'b1;
    repeat (4) tick();
    chk("mid_rst_no_wen", 32'(wen_cnt - w0), 32'd0);
    chk("mid_rst_no_commit", 32'(cm_valid), 32'd0);

    // Back-to-back stream, three cycles per instruction
    wq.delete();
    cq.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(32'h8000_1000 + 32'(i * 16), 32'h8000_1004 + 32'(i * 16), 32'(i * 17 + 1),
            32'h0, 32'h0, 2'd0, 3'd2, 5'(i + 1), 1'b1);
      repeat (3) tick();
    end
    in_valid = 1'b0;
    chk("s_commits", 32'(cq.size()), 32'd8);
    chk("s_writes", 32'(wq.size()), 32'd8);
    chk("s_ready_end", 32'(in_ready), 32'd1);
    chk("s_cm_end", 32'(cm_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i < cq.size()) chk("s_commit_pc", cq[i], 32'h8000_1000 + 32'(i * 16));
      if (i < wq.size()) chk("s_write_data", wq[i], 32'(i * 17 + 1));
    end
    tick();
    chk("s_quiet", 32'(rf_wen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
